// File: rtl/riscv_divider_if_pkg.sv
// Shared definitions for the divider slave: AHB encodings, register map,
// status bit positions and the bus/core state types.
package riscv_divider_if_pkg;

    localparam int unsigned W_BURST = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [31:0] RISCV_DIVIDER_BASE_ADDR = 32'h4000_3000;

    localparam logic [7:0] OFFS_DIVIDEND  = 8'h00;
    localparam logic [7:0] OFFS_DIVISOR   = 8'h04;
    localparam logic [7:0] OFFS_CTRL      = 8'h08;
    localparam logic [7:0] OFFS_STATUS    = 8'h0C;
    localparam logic [7:0] OFFS_QUOTIENT  = 8'h10;
    localparam logic [7:0] OFFS_REMAINDER = 8'h14;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_DBZ_BIT  = 2;
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_SIGNED_BIT = 1;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_DATA = 2'd1,
        BUS_ERR2 = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    // Word-sized access to a mapped offset; result registers and STATUS are read-only.
    function automatic logic access_legal(input logic [7:0] offs, input logic write,
                                          input logic [2:0] size);
        return (size == HSIZE_WORD) && (offs <= OFFS_REMAINDER) &&
               !(write && ((offs == OFFS_STATUS) || (offs == OFFS_QUOTIENT) ||
                           (offs == OFFS_REMAINDER)));
    endfunction

endpackage

// File: rtl/riscv_divider_if_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, signs applied in a
// final fix-up cycle. Divide-by-zero skips straight to fix-up.
module riscv_divider_if_div_core
    import riscv_divider_if_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              dbz_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    div_state_e        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d, rem_q, rem_d, divs_q, divs_d;
    logic [DATA_W-1:0] quot_q, quot_d, remres_q, remres_d;
    logic              negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
    logic              busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [DATA_W:0]   rem_shift_s;
    logic [DATA_W+1:0] diff_s;
    logic              ge_s;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? ((~v) + DATA_W'(1)) : v;
    endfunction

    assign rem_shift_s = {rem_q, acc_q[DATA_W-1]};
    assign diff_s      = {1'b0, rem_shift_s} - {2'b00, divs_q};
    assign ge_s        = ~diff_s[DATA_W+1];

    // Next-state and datapath update for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        divs_d   = divs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        zero_d   = zero_q;
        done_d   = done_q;
        dbz_d    = dbz_q;
        quot_d   = quot_q;
        remres_d = remres_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    done_d = 1'b0;
                    dbz_d  = 1'b0;
                    negq_d = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                    negr_d = signed_i & dividend_i[DATA_W-1];
                    if (divisor_i == '0) begin
                        zero_d  = 1'b1;
                        rem_d   = dividend_i;
                        state_d = DIV_FIX;
                    end else begin
                        zero_d  = 1'b0;
                        acc_d   = cond_neg(dividend_i, signed_i & dividend_i[DATA_W-1]);
                        divs_d  = cond_neg(divisor_i, signed_i & divisor_i[DATA_W-1]);
                        rem_d   = '0;
                        cnt_d   = 6'(DATA_W - 1);
                        state_d = DIV_CALC;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                acc_d = {acc_q[DATA_W-2:0], ge_s};
                rem_d = ge_s ? diff_s[DATA_W-1:0] : rem_shift_s[DATA_W-1:0];
                if (cnt_q == 6'd0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DIV_FIX: begin
                done_d = 1'b1;
                dbz_d  = zero_q;
                if (zero_q) begin
                    quot_d   = '1;
                    remres_d = rem_q;
                end else begin
                    quot_d   = cond_neg(acc_q, negq_q);
                    remres_d = cond_neg(rem_q, negr_q);
                end
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        busy_d = (state_d != DIV_IDLE);
    end

    // Core state and result registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= '0;
            rem_q    <= '0;
            divs_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quot_q   <= '0;
            remres_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            divs_q   <= divs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            quot_q   <= quot_d;
            remres_q <= remres_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbz_o       = dbz_q;
    assign quotient_o  = quot_q;
    assign remainder_o = remres_q;

endmodule

// File: rtl/riscv_divider_if.sv
// AHB-Lite slave front end for the divider: address/data phase tracking,
// wait-state insertion while the core is busy, two-cycle ERROR responses.
module riscv_divider_if
    import riscv_divider_if_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OFFS_MSB = 4
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               sl_HREADY,
    input  logic               sl_HSEL,
    input  logic [1:0]         sl_HTRANS,
    input  logic [W_BURST-1:0] sl_HBURST,
    input  logic [2:0]         sl_HSIZE,
    input  logic [ADDR_W-1:0]  sl_HADDR,
    input  logic               sl_HWRITE,
    input  logic [DATA_W-1:0]  sl_HWDATA,
    output logic               out_sl_HREADY,
    output logic [1:0]         out_sl_HRESP,
    output logic [DATA_W-1:0]  out_sl_HRDATA
);

    bus_state_e        state_q, state_d;
    logic [7:0]        offs_q, offs_s;
    logic              write_q, legal_q, signed_q;
    logic [DATA_W-1:0] dividend_q, divisor_q;
    logic              accept_s, capture_s, complete_s, wr_s, start_s, stall_s;
    logic              hready_s;
    logic [1:0]        hresp_s;
    logic [DATA_W-1:0] hrdata_s;
    logic              core_busy_s, core_done_s, core_dbz_s;
    logic [DATA_W-1:0] quot_s, rem_s;
    logic              unused_bits_s;

    assign unused_bits_s = ^{sl_HBURST, sl_HTRANS[0], sl_HADDR[ADDR_W-1:OFFS_MSB+1], sl_HADDR[1:0]};
    assign accept_s      = sl_HSEL & sl_HTRANS[1] & sl_HREADY;
    assign offs_s        = 8'({sl_HADDR[OFFS_MSB:2], 2'b00});
    // STATUS reads are the only access allowed to complete while the core runs.
    assign stall_s       = core_busy_s & ~((offs_q == OFFS_STATUS) & ~write_q);

    // Bus phase sequencing and response generation.
    always_comb begin
        state_d    = state_q;
        hready_s   = 1'b1;
        hresp_s    = HRESP_OKAY;
        complete_s = 1'b0;
        case (state_q)
            BUS_IDLE: state_d = accept_s ? BUS_DATA : BUS_IDLE;
            BUS_DATA: begin
                if (!legal_q) begin
                    hready_s = 1'b0;
                    hresp_s  = HRESP_ERROR;
                    state_d  = BUS_ERR2;
                end else if (stall_s) begin
                    hready_s = 1'b0;
                    state_d  = BUS_DATA;
                end else begin
                    complete_s = 1'b1;
                    state_d    = accept_s ? BUS_DATA : BUS_IDLE;
                end
            end
            BUS_ERR2: begin
                hresp_s = HRESP_ERROR;
                state_d = accept_s ? BUS_DATA : BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    assign capture_s = accept_s & hready_s;
    assign wr_s      = complete_s & write_q;
    assign start_s   = wr_s & (offs_q == OFFS_CTRL) & sl_HWDATA[CTRL_START_BIT];

    // Read data mux, only driven in the completing read cycle.
    always_comb begin
        hrdata_s = '0;
        if (complete_s && !write_q) begin
            case (offs_q)
                OFFS_DIVIDEND:  hrdata_s = dividend_q;
                OFFS_DIVISOR:   hrdata_s = divisor_q;
                OFFS_CTRL:      hrdata_s[CTRL_SIGNED_BIT] = signed_q;
                OFFS_STATUS: begin
                    hrdata_s[STATUS_BUSY_BIT] = core_busy_s;
                    hrdata_s[STATUS_DONE_BIT] = core_done_s;
                    hrdata_s[STATUS_DBZ_BIT]  = core_dbz_s;
                end
                OFFS_QUOTIENT:  hrdata_s = quot_s;
                OFFS_REMAINDER: hrdata_s = rem_s;
                default:        hrdata_s = '0;
            endcase
        end else begin
            hrdata_s = '0;
        end
    end

    // Address-phase capture and register file writes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= BUS_IDLE;
            offs_q     <= 8'h00;
            write_q    <= 1'b0;
            legal_q    <= 1'b0;
            signed_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture_s) begin
                offs_q  <= offs_s;
                write_q <= sl_HWRITE;
                legal_q <= access_legal(offs_s, sl_HWRITE, sl_HSIZE);
            end
            if (wr_s) begin
                case (offs_q)
                    OFFS_DIVIDEND: dividend_q <= sl_HWDATA;
                    OFFS_DIVISOR:  divisor_q  <= sl_HWDATA;
                    OFFS_CTRL:     signed_q   <= sl_HWDATA[CTRL_SIGNED_BIT];
                    default: begin
                    end
                endcase
            end
        end
    end

    riscv_divider_if_div_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start_i    (start_s),
        .signed_i   (sl_HWDATA[CTRL_SIGNED_BIT]),
        .dividend_i (dividend_q),
        .divisor_i  (divisor_q),
        .busy_o     (core_busy_s),
        .done_o     (core_done_s),
        .dbz_o      (core_dbz_s),
        .quotient_o (quot_s),
        .remainder_o(rem_s)
    );

    assign out_sl_HREADY = hready_s;
    assign out_sl_HRESP  = hresp_s;
    assign out_sl_HRDATA = hrdata_s;

endmodule

// File: tb/tb_riscv_divider_if.sv
// Self-checking bench for riscv_divider_if: vector table of divisions plus
// hand-written stall, error, idle-transfer and mid-operation reset sequences.
module tb_riscv_divider_if;

    localparam logic [31:0] BASE   = 32'h4000_3000;
    localparam logic [31:0] A_DVD  = BASE + 32'h00;
    localparam logic [31:0] A_DVS  = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_QUOT = BASE + 32'h10;
    localparam logic [31:0] A_REM  = BASE + 32'h14;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sl_HSEL, sl_HWRITE;
    logic [1:0]  sl_HTRANS;
    logic [2:0]  sl_HBURST, sl_HSIZE;
    logic [31:0] sl_HADDR, sl_HWDATA;
    logic        sl_HREADY, out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;
    assign sl_HREADY = out_sl_HREADY;

    riscv_divider_if dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sl_HREADY(sl_HREADY), .sl_HSEL(sl_HSEL),
        .sl_HTRANS(sl_HTRANS), .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE),
        .sl_HADDR(sl_HADDR), .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
        .out_sl_HRDATA(out_sl_HRDATA)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] st;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic bus_idle();
        sl_HSEL   = 1'b0;
        sl_HTRANS = 2'b00;
        sl_HADDR  = 32'd0;
        sl_HWRITE = 1'b0;
        sl_HSIZE  = 3'b010;
    endtask

    // One non-pipelined transfer; returns data-phase observations.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                        output logic [1:0] resp, output logic first_err, output int done_cyc);
        @(posedge HCLK); #1;
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HADDR = addr; sl_HWRITE = wr; sl_HSIZE = size;
        @(posedge HCLK); #1;
        bus_idle();
        sl_HWDATA = wr ? wdata : 32'd0;
        waits     = 0;
        first_err = (out_sl_HREADY == 1'b0) && (out_sl_HRESP == 2'b01);
        while (!out_sl_HREADY && waits < 100) begin
            @(posedge HCLK); #1;
            waits++;
        end
        if (!out_sl_HREADY) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: HREADY still 0 after %0d cycles, expected 1", waits);
        end
        rdata    = out_sl_HRDATA;
        resp     = out_sl_HRESP;
        done_cyc = cyc;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int done_cyc);
        logic [31:0] rd; int w; logic [1:0] rsp; logic fe;
        xfer(addr, 1'b1, 3'b010, data, rd, w, rsp, fe, done_cyc);
        chk("write_resp", {30'd0, rsp}, 32'd0);
    endtask

    task automatic expect_rd(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_data, input int exp_waits);
        exp_t e; logic [31:0] rd; int w; logic [1:0] rsp; logic fe; int dc;
        sb_q.push_back('{name, exp_data, 2'b00, exp_waits});
        xfer(addr, 1'b0, 3'b010, 32'd0, rd, w, rsp, fe, dc);
        e = sb_q.pop_front();
        chk({e.name, "_data"}, rd, e.data);
        chk({e.name, "_resp"}, {30'd0, rsp}, {30'd0, e.resp});
        if (e.waits >= 0) chk({e.name, "_waits"}, w, e.waits);
    endtask

    task automatic expect_err(input string name, input logic [31:0] addr, input logic wrt,
                              input logic [2:0] size);
        exp_t e; logic [31:0] rd; int w; logic [1:0] rsp; logic fe; int dc;
        sb_q.push_back('{name, 32'd0, 2'b01, 1});
        xfer(addr, wrt, size, 32'hDEAD_BEEF, rd, w, rsp, fe, dc);
        e = sb_q.pop_front();
        chk({e.name, "_first_cycle_err"}, {31'd0, fe}, 32'd1);
        chk({e.name, "_resp"}, {30'd0, rsp}, {30'd0, e.resp});
        chk({e.name, "_waits"}, w, e.waits);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, ctrl_cyc, lat, w;
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic        fe;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          32'h2, 34};
        vecs[1] = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h2, 34};
        vecs[2] = '{32'h0000_1234, 32'd0,          1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 32'h6, 2};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,          32'h2, 34};
        vecs[4] = '{32'hFFFF_FFFF, 32'h10,         1'b0, 32'h0FFF_FFFF, 32'hF,          32'h2, 34};
        vecs[5] = '{32'd100,        32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2,          32'h2, 34};
        vecs[6] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,         32'hFFFF_FFFE, 32'h2, 34};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,          32'h8000_0000, 32'h2, 34};
        vecs[8] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          32'h2, 34};
        vecs[9] = '{32'hFFFF_FFF9, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h6, 2};
        for (int i = 10; i < 14; i++) begin
            vecs[i].a   = $urandom;
            vecs[i].b   = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            vecs[i].sgn = i[0];
            if (vecs[i].b == 32'd0) vecs[i].b = 32'd3;
            ref_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r);
            vecs[i].st  = 32'h2;
            vecs[i].lat = 34;
        end

        bus_idle();
        sl_HBURST = 3'b000;
        sl_HWDATA = 32'd0;
        HRESETn   = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_hready", {31'd0, out_sl_HREADY}, 32'd1);
        chk("reset_hresp", {30'd0, out_sl_HRESP}, 32'd0);
        chk("reset_hrdata", out_sl_HRDATA, 32'd0);
        HRESETn = 1'b1;
        expect_rd("reset_status", A_STAT, 32'd0, 0);
        expect_rd("reset_quot", A_QUOT, 32'd0, 0);
        expect_rd("reset_ctrl", A_CTRL, 32'd0, 0);

        for (int i = 0; i < 14; i++) begin
            wr(A_DVD, vecs[i].a, dc);
            wr(A_DVS, vecs[i].b, dc);
            wr(A_CTRL, {30'd0, vecs[i].sgn, 1'b1}, ctrl_cyc);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                xfer(A_STAT, 1'b0, 3'b010, 32'd0, rd, w, rsp, fe, dc);
                if (rd[0] == 1'b0) begin
                    lat = dc - ctrl_cyc;
                    break;
                end
            end
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_poll_status", i), rd, vecs[i].st);
            expect_rd($sformatf("vec%0d_quot", i), A_QUOT, vecs[i].q, 0);
            expect_rd($sformatf("vec%0d_rem", i), A_REM, vecs[i].r, 0);
            expect_rd($sformatf("vec%0d_status", i), A_STAT, vecs[i].st, 0);
            expect_rd($sformatf("vec%0d_ctrl", i), A_CTRL, {30'd0, vecs[i].sgn, 1'b0}, 0);
        end

        // Quotient read issued right after start stalls until the core finishes.
        wr(A_DVD, 32'd100, dc);
        wr(A_DVS, 32'd7, dc);
        wr(A_CTRL, 32'h1, dc);
        expect_rd("stall_quot", A_QUOT, 32'd14, 32);
        expect_rd("stall_status_after", A_STAT, 32'h2, 0);

        // CTRL write without start: signed updates, done stays set.
        wr(A_CTRL, 32'h2, dc);
        expect_rd("nostart_status", A_STAT, 32'h2, 0);
        expect_rd("nostart_ctrl", A_CTRL, 32'h2, 0);
        expect_rd("nostart_quot", A_QUOT, 32'd14, 0);

        expect_err("err_rd_0x18", BASE + 32'h18, 1'b0, 3'b010);
        expect_err("err_half_wr_0x00", A_DVD, 1'b1, 3'b001);
        expect_err("err_wr_0x10", A_QUOT, 1'b1, 3'b010);
        expect_err("err_wr_status", A_STAT, 1'b1, 3'b010);
        expect_rd("post_err_dividend", A_DVD, 32'd100, 0);
        expect_rd("post_err_quot", A_QUOT, 32'd14, 0);
        expect_rd("post_err_status", A_STAT, 32'h2, 0);

        // BUSY then IDLE transfers to CTRL with start data must be ignored.
        @(posedge HCLK); #1;
        sl_HSEL = 1'b1; sl_HTRANS = 2'b01; sl_HADDR = A_CTRL; sl_HWRITE = 1'b1; sl_HWDATA = 32'h3;
        @(posedge HCLK); #1;
        chk("htrans_busy_hready", {31'd0, out_sl_HREADY}, 32'd1);
        chk("htrans_busy_hresp", {30'd0, out_sl_HRESP}, 32'd0);
        sl_HTRANS = 2'b00;
        @(posedge HCLK); #1;
        chk("htrans_idle_hready", {31'd0, out_sl_HREADY}, 32'd1);
        chk("htrans_idle_hresp", {30'd0, out_sl_HRESP}, 32'd0);
        bus_idle();
        expect_rd("htrans_status", A_STAT, 32'h2, 0);
        expect_rd("htrans_ctrl", A_CTRL, 32'h2, 0);

        // Reset in CALC cycle 10 while a quotient read is stalled.
        wr(A_DVD, 32'h8000_0000, dc);
        wr(A_DVS, 32'hFFFF_FFFF, dc);
        wr(A_CTRL, 32'h3, dc);
        @(posedge HCLK); #1;
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HADDR = A_QUOT; sl_HWRITE = 1'b0;
        @(posedge HCLK); #1;
        bus_idle();
        chk("midop_stalled_hready", {31'd0, out_sl_HREADY}, 32'd0);
        repeat (8) @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("midop_reset_hready", {31'd0, out_sl_HREADY}, 32'd1);
        chk("midop_reset_hresp", {30'd0, out_sl_HRESP}, 32'd0);
        chk("midop_reset_hrdata", out_sl_HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        expect_rd("midop_status", A_STAT, 32'd0, 0);
        expect_rd("midop_quot", A_QUOT, 32'd0, 0);
        expect_rd("midop_rem", A_REM, 32'd0, 0);
        expect_rd("midop_dividend", A_DVD, 32'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
